// File: rtl/scv_bus_pkg.sv
// Shared types and default SCV memory map for the uPD7800 bus block.
package scv_bus_pkg;

    typedef enum logic [2:0] {
        NONE,
        ROM,
        VRAM,
        IO,
        CART,
        IRAM
    } e_bus_region;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } e_bus_state;

    localparam logic [15:0] DEF_ROM_END   = 16'h0FFF;
    localparam logic [15:0] DEF_VRAM_BASE = 16'h2000;
    localparam logic [15:0] DEF_VRAM_END  = 16'h3FFF;
    localparam logic [15:0] DEF_IO_BASE   = 16'h3000;
    localparam logic [15:0] DEF_IO_END    = 16'h33FF;
    localparam logic [15:0] DEF_CART_BASE = 16'h8000;
    localparam logic [15:0] DEF_IRAM_BASE = 16'hFF80;
    localparam logic [7:0]  DEF_OPEN_BUS  = 8'hFF;
    localparam int          IRAM_DEPTH    = 128;

    // Priority order IRAM > IO > VRAM > ROM > CART; IO sits inside VRAM.
    function automatic e_bus_region bus_decode(
        input logic [15:0] a,
        input logic [15:0] rom_end,
        input logic [15:0] vram_base,
        input logic [15:0] vram_end,
        input logic [15:0] io_base,
        input logic [15:0] io_end,
        input logic [15:0] cart_base,
        input logic [15:0] iram_base
    );
        e_bus_region r;
        r = NONE;
        if (a >= iram_base)                       r = IRAM;
        else if (a >= io_base && a <= io_end)     r = IO;
        else if (a >= vram_base && a <= vram_end) r = VRAM;
        else if (a <= rom_end)                    r = ROM;
        else if (a >= cart_base)                  r = CART;
        return r;
    endfunction

endpackage

// File: rtl/upd7800_iram.sv
// 128x8 single-port on-chip RAM; registered read, write-first on the port.
module upd7800_iram
    import scv_bus_pkg::*;
(
    input  logic       clk_i,
    input  logic       we_i,
    input  logic [6:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [IRAM_DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_q       <= wdata_i;
        end else begin
            rdata_q       <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/upd7800_bus.sv
// SCV bus block: decodes the core's bus into chip selects, hosts the on-chip
// RAM at the top of memory and tracks each bus cycle to commit writes once.
module upd7800_bus
    import scv_bus_pkg::*;
#(
    parameter logic [15:0] ROM_END   = DEF_ROM_END,
    parameter logic [15:0] VRAM_BASE = DEF_VRAM_BASE,
    parameter logic [15:0] VRAM_END  = DEF_VRAM_END,
    parameter logic [15:0] IO_BASE   = DEF_IO_BASE,
    parameter logic [15:0] IO_END    = DEF_IO_END,
    parameter logic [15:0] CART_BASE = DEF_CART_BASE,
    parameter logic [15:0] IRAM_BASE = DEF_IRAM_BASE,
    parameter logic [7:0]  OPEN_BUS  = DEF_OPEN_BUS
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] CPU_A,
    input  logic [7:0]  CPU_DB_O,
    input  logic        CPU_RDB,
    input  logic        CPU_WRB,
    input  logic        CPU_M1,
    output logic [7:0]  CPU_DB_I,
    input  logic [7:0]  EXT_DB_I,
    output logic [7:0]  EXT_DB_O,
    output logic        ROM_CSB,
    output logic        VRAM_CSB,
    output logic        IO_CSB,
    output logic        CART_CSB,
    output logic        EXT_RDB,
    output logic        EXT_WRB,
    output logic        WR_COMMIT,
    output logic [15:0] FETCH_A,
    output logic        BUS_ERR,
    output logic        ROM_WR_ERR
);

    e_bus_region region, wa_region;
    e_bus_state  state_q, state_d;

    logic        access, ext_sel;
    logic        rd_q, wr_q, m1_q;
    logic [15:0] a_q;
    logic [7:0]  db_q;
    logic [15:0] wa_q, wa_d;
    logic [7:0]  wd_q, wd_d;
    logic [15:0] fetch_q, fetch_d;
    logic        bus_err_q, bus_err_d;
    logic        rom_err_q, rom_err_d;
    logic        commit, commit_en, iram_we;
    logic [6:0]  iram_addr;
    logic [7:0]  iram_rdata;

    assign region    = bus_decode(CPU_A, ROM_END, VRAM_BASE, VRAM_END,
                                  IO_BASE, IO_END, CART_BASE, IRAM_BASE);
    assign wa_region = bus_decode(wa_q, ROM_END, VRAM_BASE, VRAM_END,
                                  IO_BASE, IO_END, CART_BASE, IRAM_BASE);

    assign access  = ~CPU_RDB | ~CPU_WRB;
    assign ext_sel = (region == ROM) || (region == VRAM) ||
                     (region == IO)  || (region == CART);

    assign ROM_CSB  = ~((region == ROM)  & access);
    assign VRAM_CSB = ~((region == VRAM) & access);
    assign IO_CSB   = ~((region == IO)   & access);
    assign CART_CSB = ~((region == CART) & access);
    assign EXT_RDB  = CPU_RDB | ~ext_sel;
    assign EXT_WRB  = CPU_WRB | ~ext_sel;
    assign EXT_DB_O = RESET ? 8'h00 : CPU_DB_O;

    always_comb begin
        CPU_DB_I = OPEN_BUS;
        if (!CPU_RDB) begin
            if (region == IRAM) CPU_DB_I = iram_rdata;
            else if (ext_sel)   CPU_DB_I = EXT_DB_I;
        end
    end

    // The FSM runs one CLK behind the pins on a registered copy of the bus,
    // so address and data seen at entry/commit line up with the strobes.
    always_comb begin
        state_d   = state_q;
        wa_d      = wa_q;
        wd_d      = wd_q;
        fetch_d   = fetch_q;
        bus_err_d = bus_err_q;
        rom_err_d = rom_err_q;
        commit    = 1'b0;
        if (!rd_q && !wr_q) begin
            bus_err_d = 1'b1;
            state_d   = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rd_q) begin
                        state_d = READ;
                        if (m1_q) fetch_d = a_q;
                    end else if (!wr_q) begin
                        state_d = WRITE;
                        wa_d    = a_q;
                        wd_d    = db_q;
                    end
                end
                READ: begin
                    if (!wr_q) begin
                        bus_err_d = 1'b1;
                        state_d   = IDLE;
                    end else if (rd_q) begin
                        state_d = IDLE;
                    end
                end
                WRITE: begin
                    if (!rd_q) begin
                        bus_err_d = 1'b1;
                        state_d   = IDLE;
                    end else if (wr_q) begin
                        state_d = IDLE;
                        commit  = 1'b1;
                        if (wa_region == ROM) rom_err_d = 1'b1;
                    end else begin
                        wd_d = db_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            m1_q      <= 1'b0;
            a_q       <= 16'h0000;
            db_q      <= 8'h00;
            wa_q      <= 16'h0000;
            wd_q      <= 8'h00;
            fetch_q   <= 16'h0000;
            bus_err_q <= 1'b0;
            rom_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= CPU_RDB;
            wr_q      <= CPU_WRB;
            m1_q      <= CPU_M1;
            a_q       <= CPU_A;
            db_q      <= CPU_DB_O;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            fetch_q   <= fetch_d;
            bus_err_q <= bus_err_d;
            rom_err_q <= rom_err_d;
        end
    end

    assign commit_en  = commit & ~RESET;
    assign iram_we    = commit_en & (wa_region == IRAM);
    assign iram_addr  = commit_en ? wa_q[6:0] : CPU_A[6:0];
    assign WR_COMMIT  = commit_en;
    assign FETCH_A    = fetch_q;
    assign BUS_ERR    = bus_err_q;
    assign ROM_WR_ERR = rom_err_q;

    upd7800_iram u_iram (
        .clk_i   (CLK),
        .we_i    (iram_we),
        .addr_i  (iram_addr),
        .wdata_i (wd_q),
        .rdata_o (iram_rdata)
    );

endmodule
